// File: rtl/seq_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer:
// FSM states, instruction type codes, key opcodes and PC source selects.
package seq_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT,
    ERROR
  } state_t;

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_J = 2'b01;
  localparam logic [1:0] TYPE_I = 2'b10;
  localparam logic [1:0] TYPE_S = 2'b11;

  localparam logic [4:0] OP_LW = 5'd2;
  localparam logic [4:0] OP_SW = 5'd3;
  localparam logic [4:0] OP_BR = 5'd4;

  localparam logic [1:0] PCS_SEQ = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;
  localparam logic [1:0] PCS_BR  = 2'b11;

  function automatic logic opcode_legal(input logic [1:0] ins_type, input logic [4:0] opcode);
    logic ok;
    case (ins_type)
      TYPE_R:  ok = (opcode <= 5'd3);
      TYPE_J:  ok = (opcode <= 5'd1);
      TYPE_I:  ok = (opcode <= 5'd4);
      default: ok = (opcode <= 5'd3);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has been held without acknowledge and
// flags the last allowed cycle so the sequencer can abort to ERROR.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic timeout
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Fires during the final unacknowledged request cycle.
  assign timeout = count && (cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, write-back.
// Optional perf counters are built when SEQ_PERF_CNT_EN is defined.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ins_type,
  input  logic [4:0]       opcode,
  input  logic             stop,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             wb_sel,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count
);

  state_t state, next_state;
  logic   stop_q;
  logic   retire, set_bus, set_ill, latch_stop;
  logic   is_load, is_store, is_branch;
  logic   req_state, ack_sel, timeout;

  assign is_load   = (ins_type == TYPE_I) && (opcode == OP_LW);
  assign is_store  = (ins_type == TYPE_I) && (opcode == OP_SW);
  assign is_branch = (ins_type == TYPE_I) && (opcode == OP_BR);

  assign req_state = (state == FETCH) || (state == MEM);
  assign ack_sel   = (state == FETCH) ? imem_ack : dmem_ack;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!req_state || ack_sel),
    .count  (req_state && !ack_sel),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      stop_q      <= 1'b0;
      bus_err     <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (latch_stop) stop_q <= stop;
      if (set_bus) bus_err <= 1'b1;
      if (set_ill) illegal <= 1'b1;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    set_bus    = 1'b0;
    set_ill    = 1'b0;
    latch_stop = 1'b0;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    wb_sel     = 1'b0;
    halted     = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PCS_SEQ;
          next_state = DECODE;
        end else if (timeout) begin
          set_bus    = 1'b1;
          next_state = ERROR;
        end
      end
      DECODE: begin
        latch_stop = 1'b1;
        if (!opcode_legal(ins_type, opcode)) begin
          set_ill    = 1'b1;
          next_state = ERROR;
        end else begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (ins_type == TYPE_J) begin
          pc_write = 1'b1;
          pc_src   = PCS_JMP;
          retire   = 1'b1;
        end else if (is_branch) begin
          pc_write = zero;
          pc_src   = PCS_BR;
          retire   = 1'b1;
        end else if (is_load || is_store) begin
          next_state = MEM;
        end else begin
          next_state = WB;
        end
      end
      MEM: begin
        dmem_rd = is_load;
        dmem_wr = !is_load;
        if (dmem_ack) begin
          if (is_load) next_state = WB;
          else         retire     = 1'b1;
        end else if (timeout) begin
          set_bus    = 1'b1;
          next_state = ERROR;
        end
      end
      WB: begin
        reg_write = 1'b1;
        wb_sel    = is_load;
        retire    = 1'b1;
      end
      default: begin
        halted = 1'b1;
      end
    endcase
    if (retire) next_state = stop_q ? HALT : FETCH;
    // Outputs must fall the moment reset asserts, not at the next edge.
    if (!rst) begin
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      reg_write = 1'b0;
      dmem_rd   = 1'b0;
      dmem_wr   = 1'b0;
      wb_sel    = 1'b0;
      halted    = 1'b0;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic stall;
  assign stall = (imem_req && !imem_ack) || ((dmem_rd || dmem_wr) && !dmem_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_W'(1);
      stall_count <= stall_count + CNT_W'(stall);
    end
  end
`else
  assign cycle_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench for multicycle_sequencer using a
// per-instruction expected-trace model built from the instruction rules.
module tb_multicycle_sequencer;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ins_type;
  logic [4:0]  opcode;
  logic        stop, zero, imem_ack, dmem_ack;
  logic        imem_req, ir_write, pc_write, reg_write, dmem_rd, dmem_wr, wb_sel;
  logic        halted, bus_err, illegal;
  logic [1:0]  pc_src;
  logic [31:0] instr_count, cycle_count, stall_count;

  multicycle_sequencer #(.CNT_W(32), .MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .ins_type(ins_type), .opcode(opcode), .stop(stop),
    .zero(zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .wb_sel(wb_sel), .halted(halted),
    .bus_err(bus_err), .illegal(illegal), .instr_count(instr_count),
    .cycle_count(cycle_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Reference model state
  logic [9:0]  exp_q[$], obs_q[$];
  logic [31:0] m_icount, m_cycles, m_stall;
  bit          m_halt, m_bus, m_ill;

  // Vector: req ir pcw pcs[1:0] rw rd wr wbs halted
  function automatic logic [9:0] mk(bit req, bit ir, bit pcw, logic [1:0] pcs,
                                    bit rw, bit rd, bit wr, bit wbs, bit h);
    return {req, ir, pcw, pcs, rw, rd, wr, wbs, h};
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] exp_cyc();
`ifdef SEQ_PERF_CNT_EN
    return m_cycles;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_stall();
`ifdef SEQ_PERF_CNT_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick(input bit ia, input bit da, input bit st, input bit z, input logic [9:0] e);
    imem_ack = ia; dmem_ack = da; stop = st; zero = z;
    @(negedge clk);
    obs_q.push_back({imem_req, ir_write, pc_write, pc_src, reg_write, dmem_rd, dmem_wr, wb_sel, halted});
    exp_q.push_back(e);
    if ((e[9] && !ia) || ((e[3] || e[2]) && !da)) m_stall++;
    @(posedge clk); #1;
    m_cycles++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(rb(), rb(), rb(), rb(), mk(0,0,0,2'b00,0,0,0,0,1));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_icount = 0; m_cycles = 0; m_stall = 0;
    m_halt = 0; m_bus = 0; m_ill = 0;
    exp_q.delete(); obs_q.delete();
  endtask

  // Drives one instruction and appends the expected per-cycle outputs.
  task automatic run_instr(input logic [1:0] t, input logic [4:0] op, input bit stp,
                           input bit z, input int fdly, input int mdly);
    bit lg, ld, sw, br;
    ins_type = t; opcode = op;
    case (t)
      2'd0:    lg = (op < 4);
      2'd1:    lg = (op < 2);
      2'd2:    lg = (op < 5);
      default: lg = (op < 4);
    endcase
    ld = (t == 2) && (op == 2);
    sw = (t == 2) && (op == 3);
    br = (t == 2) && (op == 4);
    for (int i = 0; i < fdly && i < T; i++) tick(0, rb(), rb(), rb(), mk(1,0,0,2'b00,0,0,0,0,0));
    if (fdly >= T) begin m_bus = 1; m_halt = 1; return; end
    tick(1, rb(), rb(), rb(), mk(1,1,1,2'b01,0,0,0,0,0));
    tick(rb(), rb(), stp, rb(), mk(0,0,0,2'b00,0,0,0,0,0));
    if (!lg) begin m_ill = 1; m_halt = 1; return; end
    if (t == 1) begin
      tick(rb(), rb(), rb(), z, mk(0,0,1,2'b10,0,0,0,0,0));
      m_icount++; if (stp) m_halt = 1; return;
    end
    if (br) begin
      tick(rb(), rb(), rb(), z, mk(0,0,z,2'b11,0,0,0,0,0));
      m_icount++; if (stp) m_halt = 1; return;
    end
    tick(rb(), rb(), rb(), z, mk(0,0,0,2'b00,0,0,0,0,0));
    if (ld || sw) begin
      for (int i = 0; i < mdly && i < T; i++) tick(rb(), 0, rb(), rb(), mk(0,0,0,2'b00,0,ld,sw,0,0));
      if (mdly >= T) begin m_bus = 1; m_halt = 1; return; end
      tick(rb(), 1, rb(), rb(), mk(0,0,0,2'b00,0,ld,sw,0,0));
      if (sw) begin m_icount++; if (stp) m_halt = 1; return; end
    end
    tick(rb(), rb(), rb(), rb(), mk(0,0,0,2'b00,1,0,0,ld,0));
    m_icount++; if (stp) m_halt = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ins_type = 0; opcode = 0; stop = 0; zero = 0; imem_ack = 0; dmem_ack = 0;
    #2;
    n_chk++;
    if ({imem_req, ir_write, pc_write, pc_src, reg_write, dmem_rd, dmem_wr, wb_sel, halted} !== 10'b0) begin
      n_fail++; $display("FAIL reset_outputs got %b exp 0", {imem_req, ir_write, pc_write, pc_src, halted});
    end else n_pass++;
    n_chk++;
    if ({instr_count, cycle_count, stall_count, bus_err, illegal} !== '0) begin
      n_fail++; $display("FAIL reset_state got icnt=%0d cyc=%0d stl=%0d be=%b il=%b exp all 0",
                         instr_count, cycle_count, stall_count, bus_err, illegal);
    end else n_pass++;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_release_fetch got %b exp 1", imem_req); end
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_r_add();
    do_reset();
    run_instr(2'd0, 5'd0, 0, rb(), 0, 0);
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL r_add_trace cyc %0d got %b exp %b", i, obs_q[i], exp_q[i]); end
      else n_pass++;
    end
    n_chk++;
    if (instr_count !== 32'd1) begin n_fail++; $display("FAIL r_add_count got %0d exp 1", instr_count); end
    else n_pass++;
    n_chk++;
    if (cycle_count !== exp_cyc() || stall_count !== exp_stall()) begin
      n_fail++; $display("FAIL r_add_perf got %0d/%0d exp %0d/%0d", cycle_count, stall_count, exp_cyc(), exp_stall());
    end else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_load();
    int rd_cycles = 0;
    do_reset();
    run_instr(2'd2, 5'd2, 0, rb(), 0, 3);
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL load_trace cyc %0d got %b exp %b", i, obs_q[i], exp_q[i]); end
      else n_pass++;
      rd_cycles += int'(obs_q[i][3]);
    end
    n_chk++;
    if (rd_cycles != 4) begin n_fail++; $display("FAIL load_rd_cycles got %0d exp 4", rd_cycles); end
    else n_pass++;
    n_chk++;
    if (instr_count !== m_icount) begin n_fail++; $display("FAIL load_count got %0d exp %0d", instr_count, m_icount); end
    else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_branch();
    do_reset();
    run_instr(2'd2, 5'd4, 0, 1, 0, 0);
    run_instr(2'd2, 5'd4, 0, 0, 1, 0);
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL branch_trace cyc %0d got %b exp %b", i, obs_q[i], exp_q[i]); end
      else n_pass++;
    end
    n_chk++;
    if (instr_count !== 32'd2) begin n_fail++; $display("FAIL branch_count got %0d exp 2", instr_count); end
    else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_fetch_timeout();
    int req_cycles = 0;
    do_reset();
    run_instr(2'd0, 5'd1, 0, rb(), 0, 0);
    run_instr(2'd0, 5'd0, 0, rb(), T, 0);
    idle(3);
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ftimeout_trace cyc %0d got %b exp %b", i, obs_q[i], exp_q[i]); end
      else n_pass++;
      if (i >= 4) req_cycles += int'(obs_q[i][9]);
    end
    n_chk++;
    if (req_cycles != T) begin n_fail++; $display("FAIL ftimeout_req_cycles got %0d exp %0d", req_cycles, T); end
    else n_pass++;
    n_chk++;
    if (bus_err !== 1'b1 || illegal !== 1'b0 || instr_count !== 32'd1) begin
      n_fail++; $display("FAIL ftimeout_state got be=%b il=%b icnt=%0d exp be=1 il=0 icnt=1", bus_err, illegal, instr_count);
    end else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(2'd0, 5'd5, 0, rb(), 0, 0);
    idle(2);
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL illegal_trace cyc %0d got %b exp %b", i, obs_q[i], exp_q[i]); end
      else n_pass++;
    end
    n_chk++;
    if (illegal !== 1'b1 || bus_err !== 1'b0 || instr_count !== 32'd0) begin
      n_fail++; $display("FAIL illegal_state got il=%b be=%b icnt=%0d exp il=1 be=0 icnt=0", illegal, bus_err, instr_count);
    end else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_store_stop();
    do_reset();
    run_instr(2'd2, 5'd3, 1, rb(), 2, 2);
    idle(3);
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL store_stop_trace cyc %0d got %b exp %b", i, obs_q[i], exp_q[i]); end
      else n_pass++;
    end
    n_chk++;
    if (instr_count !== 32'd1 || halted !== 1'b1 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL store_stop_state got icnt=%0d h=%b be=%b exp 1 1 0", instr_count, halted, bus_err);
    end else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_mem_timeout();
    do_reset();
    run_instr(2'd2, 5'd2, 0, rb(), 0, T + 2);
    idle(2);
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mtimeout_trace cyc %0d got %b exp %b", i, obs_q[i], exp_q[i]); end
      else n_pass++;
    end
    n_chk++;
    if (bus_err !== 1'b1 || instr_count !== 32'd0) begin
      n_fail++; $display("FAIL mtimeout_state got be=%b icnt=%0d exp be=1 icnt=0", bus_err, instr_count);
    end else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    ins_type = 2'd2; opcode = 5'd3;
    tick(1, 0, 0, 0, mk(1,1,1,2'b01,0,0,0,0,0));
    tick(0, 0, 0, 0, mk(0,0,0,2'b00,0,0,0,0,0));
    tick(0, 0, 0, 0, mk(0,0,0,2'b00,0,0,0,0,0));
    tick(0, 0, 0, 0, mk(0,0,0,2'b00,0,0,1,0,0));
    tick(0, 0, 0, 0, mk(0,0,0,2'b00,0,0,1,0,0));
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_mem_trace cyc %0d got %b exp %b", i, obs_q[i], exp_q[i]); end
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    #1; rst = 1'b0; #1;
    n_chk++;
    if (dmem_wr !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL mid_mem_async got wr=%b req=%b exp 0 0", dmem_wr, imem_req);
    end else n_pass++;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b1 || dmem_wr !== 1'b0 || instr_count !== 32'd0) begin
      n_fail++; $display("FAIL mid_mem_refetch got req=%b wr=%b icnt=%0d exp 1 0 0", imem_req, dmem_wr, instr_count);
    end else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_instr(2'd1, 5'd0, 0, rb(), 0, 0);
    run_instr(2'd3, 5'd2, 0, rb(), 0, 0);
    run_instr(2'd2, 5'd2, 0, rb(), 0, 0);
    run_instr(2'd2, 5'd3, 0, rb(), 0, 0);
    run_instr(2'd0, 5'd3, 1, rb(), 0, 0);
    idle(2);
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_trace cyc %0d got %b exp %b", i, obs_q[i], exp_q[i]); end
      else n_pass++;
    end
    n_chk++;
    if (instr_count !== 32'd5) begin n_fail++; $display("FAIL b2b_count got %0d exp 5", instr_count); end
    else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic [1:0] t;
    logic [4:0] op;
    int fd, md;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      t  = 2'($urandom_range(0, 3));
      op = 5'($urandom_range(0, 6));
      fd = ($urandom_range(0, 19) == 0) ? T : int'($urandom_range(0, T - 1));
      md = ($urandom_range(0, 19) == 0) ? T : int'($urandom_range(0, T - 1));
      run_instr(t, op, ($urandom_range(0, 7) == 0), rb(), fd, md);
      if (m_halt) idle(2);
      foreach (exp_q[i]) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_trace n=%0d t=%0d op=%0d cyc %0d got %b exp %b", n, t, op, i, obs_q[i], exp_q[i]);
        end else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
      n_chk++;
      if (instr_count !== m_icount || bus_err !== m_bus || illegal !== m_ill ||
          cycle_count !== exp_cyc() || stall_count !== exp_stall()) begin
        n_fail++;
        $display("FAIL rand_state n=%0d got icnt=%0d be=%b il=%b cyc=%0d stl=%0d exp %0d %b %b %0d %0d",
                 n, instr_count, bus_err, illegal, cycle_count, stall_count,
                 m_icount, m_bus, m_ill, exp_cyc(), exp_stall());
      end else n_pass++;
      if (m_halt) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_r_add();
    test_load();
    test_branch();
    test_fetch_timeout();
    test_illegal();
    test_store_stop();
    test_mem_timeout();
    test_reset_mid_mem();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
